// File: rtl/fetch_pkg.sv
// fetch_pkg: lane layout, line geometry and fetch FSM states shared by the fetch lane generator.
package fetch_pkg;
    localparam int LANE_W     = 78;
    localparam int LANES      = 8;
    localparam int LINE_BYTES = 16;
    localparam int VALID_B    = 77;
    localparam int BYTE_HI    = 76;
    localparam int BYTE_LO    = 69;
    localparam int EIP_HI     = 68;
    localparam int EIP_LO     = 37;
    localparam int TGT_HI     = 36;
    localparam int TGT_LO     = 5;
    localparam int TKN_B      = 4;
    localparam int ID_HI      = 3;
    localparam int ID_LO      = 0;

    typedef enum logic [1:0] {IDLE, REQ, STREAM} state_e;

    function automatic logic [7:0] line_byte(input logic [127:0] line, input logic [3:0] idx);
        line_byte = line[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [3:0] packet_bytes(input logic [4:0] end_off, input logic [4:0] off);
        logic [4:0] rem;
        rem = end_off - off;
        packet_bytes = (rem > 5'd8) ? 4'd8 : rem[3:0];
    endfunction
endpackage

// File: rtl/fetch_lane_mux.sv
// fetch_lane_mux: builds the eight packed lanes and the page-boundary flag from the latched line.
module fetch_lane_mux
    import fetch_pkg::*;
(
    input  logic [127:0]            line,
    input  logic [4:0]              off,
    input  logic [3:0]              n,
    input  logic [31:0]             ptr,
    input  logic [31:0]             tgt,
    input  logic                    tkn,
    input  logic [3:0]              br_off,
    input  logic [3:0]              id,
    output logic [LANES*LANE_W-1:0] lanes,
    output logic                    page_bound
);
    logic [11:0] last_lo;

    always_comb begin
        lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            if (4'(i) < n) begin
                lanes[i*LANE_W + VALID_B]                   = 1'b1;
                lanes[i*LANE_W + BYTE_LO +: BYTE_HI-BYTE_LO+1] = line_byte(line, off[3:0] + 4'(i));
                lanes[i*LANE_W + EIP_LO +: EIP_HI-EIP_LO+1]   = ptr + 32'(i);
                lanes[i*LANE_W + TGT_LO +: TGT_HI-TGT_LO+1]   = tgt;
                lanes[i*LANE_W + TKN_B]                     = tkn && (off + 5'(i) == {1'b0, br_off});
                lanes[i*LANE_W + ID_LO +: ID_HI-ID_LO+1]      = id;
            end
        end
    end

    // Only the low 12 bits of the last lane's EIP matter for the page test.
    assign last_lo    = ptr[11:0] + {8'b0, n} - 12'd1;
    assign page_bound = (n != 4'd0) && (last_lo == 12'hFFF);
endmodule

// File: rtl/fetch_lane_gen.sv
// fetch_lane_gen: requests I-cache lines and streams up to eight bytes per cycle as packed lanes to decode.
module fetch_lane_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_eip,
    output logic          icache_req,
    output logic [31:0]   icache_addr,
    input  logic          icache_ack,
    input  logic [127:0]  icache_line,
    input  logic          bp_taken,
    input  logic [31:0]   bp_tgt,
    input  logic [3:0]    bp_br_off,
    input  logic [3:0]    bp_id,
    input  logic          dec1_stall,
    output logic [77:0]   b0_out,
    output logic [77:0]   b1_out,
    output logic [77:0]   b2_out,
    output logic [77:0]   b3_out,
    output logic [77:0]   b4_out,
    output logic [77:0]   b5_out,
    output logic [77:0]   b6_out,
    output logic [77:0]   b7_out,
    output logic [3:0]    fetch_width,
    output logic          fetch_not_ready,
    output logic          page_bound
);
    state_e         state_q, state_d;
    logic [31:0]    ptr_q, ptr_d;
    logic [4:0]     off_q, off_d;
    logic [4:0]     end_q, end_d;
    logic [127:0]   line_q, line_d;
    logic [31:0]    tgt_q, tgt_d;
    logic           tkn_q, tkn_d;
    logic [3:0]     br_off_q, br_off_d;
    logic [3:0]     id_q, id_d;
    logic [3:0]     n;
    logic [4:0]     off_adv;
    logic [31:0]    ptr_adv;
    logic [LANES*LANE_W-1:0] lanes;

    assign n       = (state_q == STREAM) ? packet_bytes(end_q, off_q) : 4'd0;
    assign off_adv = off_q + {1'b0, n};
    assign ptr_adv = ptr_q + {28'b0, n};

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        off_d    = off_q;
        end_d    = end_q;
        line_d   = line_q;
        tgt_d    = tgt_q;
        tkn_d    = tkn_q;
        br_off_d = br_off_q;
        id_d     = id_q;
        if (redirect_valid) begin
            state_d = REQ;
            ptr_d   = redirect_eip;
        end else if (state_q == IDLE) begin
            state_d = REQ;
        end else if (state_q == REQ && icache_ack) begin
            // A taken branch behind the entry point cannot end this line.
            state_d  = STREAM;
            line_d   = icache_line;
            off_d    = {1'b0, ptr_q[3:0]};
            tkn_d    = bp_taken && (bp_br_off >= ptr_q[3:0]);
            end_d    = tkn_d ? {1'b0, bp_br_off} + 5'd1 : 5'(LINE_BYTES);
            tgt_d    = bp_tgt;
            br_off_d = bp_br_off;
            id_d     = bp_id;
        end else if (state_q == STREAM && !dec1_stall) begin
            off_d   = off_adv;
            ptr_d   = (off_adv == end_q && tkn_q) ? tgt_q : ptr_adv;
            state_d = (off_adv == end_q) ? REQ : STREAM;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= RESET_EIP;
            off_q    <= '0;
            end_q    <= '0;
            line_q   <= '0;
            tgt_q    <= '0;
            tkn_q    <= 1'b0;
            br_off_q <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            off_q    <= off_d;
            end_q    <= end_d;
            line_q   <= line_d;
            tgt_q    <= tgt_d;
            tkn_q    <= tkn_d;
            br_off_q <= br_off_d;
            id_q     <= id_d;
        end
    end

    fetch_lane_mux u_mux (
        .line       (line_q),
        .off        (off_q),
        .n          (n),
        .ptr        (ptr_q),
        .tgt        (tgt_q),
        .tkn        (tkn_q),
        .br_off     (br_off_q),
        .id         (id_q),
        .lanes      (lanes),
        .page_bound (page_bound)
    );

    assign icache_req      = (state_q == REQ);
    assign icache_addr     = icache_req ? {ptr_q[31:4], 4'h0} : 32'h0;
    assign fetch_not_ready = (state_q != STREAM);
    assign fetch_width     = n;
    assign b0_out          = lanes[0*LANE_W +: LANE_W];
    assign b1_out          = lanes[1*LANE_W +: LANE_W];
    assign b2_out          = lanes[2*LANE_W +: LANE_W];
    assign b3_out          = lanes[3*LANE_W +: LANE_W];
    assign b4_out          = lanes[4*LANE_W +: LANE_W];
    assign b5_out          = lanes[5*LANE_W +: LANE_W];
    assign b6_out          = lanes[6*LANE_W +: LANE_W];
    assign b7_out          = lanes[7*LANE_W +: LANE_W];
endmodule

// File: tb/tb_fetch_lane_gen.sv
// tb_fetch_lane_gen: directed checks of the fetch lane generator with hand-computed expectations.
module tb_fetch_lane_gen;
    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_eip = '0;
    logic          icache_req;
    logic [31:0]   icache_addr;
    logic          icache_ack = 1'b0;
    logic [127:0]  icache_line = '0;
    logic          bp_taken = 1'b0;
    logic [31:0]   bp_tgt = '0;
    logic [3:0]    bp_br_off = '0;
    logic [3:0]    bp_id = '0;
    logic          dec1_stall = 1'b0;
    logic [77:0]   b0_out, b1_out, b2_out, b3_out, b4_out, b5_out, b6_out, b7_out;
    logic [3:0]    fetch_width;
    logic          fetch_not_ready;
    logic          page_bound;
    logic [77:0]   b [8];
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 CLK = ~CLK;

    assign b[0] = b0_out;
    assign b[1] = b1_out;
    assign b[2] = b2_out;
    assign b[3] = b3_out;
    assign b[4] = b4_out;
    assign b[5] = b5_out;
    assign b[6] = b6_out;
    assign b[7] = b7_out;

    fetch_lane_gen dut (
        .CLK(CLK), .reset(reset), .redirect_valid(redirect_valid), .redirect_eip(redirect_eip),
        .icache_req(icache_req), .icache_addr(icache_addr), .icache_ack(icache_ack),
        .icache_line(icache_line), .bp_taken(bp_taken), .bp_tgt(bp_tgt), .bp_br_off(bp_br_off),
        .bp_id(bp_id), .dec1_stall(dec1_stall),
        .b0_out(b0_out), .b1_out(b1_out), .b2_out(b2_out), .b3_out(b3_out),
        .b4_out(b4_out), .b5_out(b5_out), .b6_out(b6_out), .b7_out(b7_out),
        .fetch_width(fetch_width), .fetch_not_ready(fetch_not_ready), .page_bound(page_bound)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic go(input logic [31:0] eip);
        redirect_valid = 1'b1;
        redirect_eip   = eip;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic ack(input logic tkn, input logic [3:0] br_off, input logic [31:0] tgt, input logic [3:0] id);
        icache_ack = 1'b1;
        bp_taken   = tkn;
        bp_br_off  = br_off;
        bp_tgt     = tgt;
        bp_id      = id;
        step();
        icache_ack = 1'b0;
        bp_taken   = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) icache_line[8*k +: 8] = 8'(k);
        step();
        step();
        chk("rst_req", icache_req, 0);
        chk("rst_addr", icache_addr, 0);
        chk("rst_width", fetch_width, 0);
        chk("rst_fnr", fetch_not_ready, 1);
        chk("rst_pb", page_bound, 0);
        chk("rst_b0", b[0], 0);
        chk("rst_b7", b[7], 0);
        reset = 1'b0;
        step();
        chk("idle_to_req", icache_req, 1);
        chk("req_reset_addr", icache_addr, 32'h0);

        go(32'h1000);
        chk("go_addr", icache_addr, 32'h1000);
        chk("go_fnr", fetch_not_ready, 1);
        ack(0, 0, 0, 0);
        chk("l1_width0", fetch_width, 8);
        chk("l1_fnr0", fetch_not_ready, 0);
        chk("l1_eip0", b[0][68:37], 32'h1000);
        chk("l1_byte0", b[0][76:69], 8'h00);
        chk("l1_b7eip0", b[7][68:37], 32'h1007);
        chk("l1_pb0", page_bound, 0);
        chk("l1_req_stream", icache_req, 0);
        step();
        chk("l1_width1", fetch_width, 8);
        chk("l1_eip1", b[0][68:37], 32'h1008);
        chk("l1_byte1", b[0][76:69], 8'h08);
        chk("l1_byte7", b[7][76:69], 8'h0F);
        step();
        chk("l1_bubble_fnr", fetch_not_ready, 1);
        chk("l1_next_addr", icache_addr, 32'h1010);

        go(32'h100D);
        ack(0, 0, 0, 0);
        chk("tail_width", fetch_width, 3);
        chk("tail_eip", b[0][68:37], 32'h100D);
        chk("tail_byte", b[0][76:69], 8'h0D);
        chk("tail_b2byte", b[2][76:69], 8'h0F);
        for (int i = 3; i < 8; i++) chk($sformatf("tail_zero_b%0d", i), b[i], 0);
        step();
        chk("tail_next_addr", icache_addr, 32'h1010);

        go(32'h1000);
        ack(1, 4'd5, 32'h2000, 4'h3);
        chk("br_width", fetch_width, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("br_tkn_b%0d", i), b[i][4], (i == 5) ? 1 : 0);
            chk($sformatf("br_id_b%0d", i), b[i][3:0], 4'h3);
            chk($sformatf("br_tgt_b%0d", i), b[i][36:5], 32'h2000);
        end
        chk("br_b6_zero", b[6], 0);
        step();
        chk("br_next_addr", icache_addr, 32'h2000);

        go(32'h1008);
        ack(1, 4'd5, 32'h5000, 4'h1);
        chk("behind_width", fetch_width, 8);
        chk("behind_eip", b[0][68:37], 32'h1008);
        for (int i = 0; i < 8; i++) chk($sformatf("behind_tkn_b%0d", i), b[i][4], 0);
        step();
        chk("behind_next_addr", icache_addr, 32'h1010);

        go(32'h1000);
        ack(0, 0, 32'h0, 4'h7);
        dec1_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall%0d_width", c), fetch_width, 8);
            chk($sformatf("stall%0d_eip", c), b[0][68:37], 32'h1000);
            chk($sformatf("stall%0d_byte", c), b[0][76:69], 8'h00);
            chk($sformatf("stall%0d_b7", c), b[7], {1'b1, 8'h07, 32'h1007, 32'h0, 1'b0, 4'h7});
        end
        dec1_stall = 1'b0;
        step();
        chk("unstall_eip", b[0][68:37], 32'h1008);
        chk("unstall_byte", b[0][76:69], 8'h08);
        step();

        go(32'h1000);
        ack(0, 0, 0, 0);
        redirect_valid = 1'b1;
        redirect_eip   = 32'h3004;
        icache_ack     = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("redir_fnr", fetch_not_ready, 1);
        chk("redir_req", icache_req, 1);
        chk("redir_addr", icache_addr, 32'h3000);
        chk("redir_width", fetch_width, 0);
        step();
        icache_ack = 1'b0;
        chk("redir_ack_width", fetch_width, 8);
        chk("redir_ack_eip", b[0][68:37], 32'h3004);
        chk("redir_ack_byte", b[0][76:69], 8'h04);

        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_eip   = 32'h7000;
        icache_ack     = 1'b1;
        step();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        icache_ack     = 1'b0;
        chk("midrst_req", icache_req, 0);
        chk("midrst_fnr", fetch_not_ready, 1);
        chk("midrst_width", fetch_width, 0);
        step();
        chk("midrst_addr", icache_addr, 32'h0);

        go(32'h1FF8);
        ack(0, 0, 0, 0);
        chk("page_width", fetch_width, 8);
        chk("page_bound", page_bound, 1);
        chk("page_b7eip", b[7][68:37], 32'h1FFF);
        step();
        chk("page_pb_clear", page_bound, 0);
        chk("page_next_addr", icache_addr, 32'h2000);

        go(32'hFFFF_FFF8);
        ack(0, 0, 0, 0);
        chk("wrap_width", fetch_width, 8);
        step();
        chk("wrap_req", icache_req, 1);
        chk("wrap_addr", icache_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
